pdm_audio_frontend: RTL and testbench

Parametrised audio front end that replaces the fixed 3-stage microphone synchronizer and 2-way speaker mux in the top level. It generates the PDM microphone clock, synchronizes and samples the PDM bit stream, and decimates it into PCM samples (boxcar ones-count) buffered in a small FIFO with a valid/ready handshake. It drives the audio PWM output in one of four modes. Sits between the board audio pins and the embedded system, clocked by `clk_100MHz`.

---
 rtl/audio_pkg.sv | 15 +
 rtl/pcm_fifo.sv | 38 +++
 rtl/pdm_audio_frontend.sv | 97 +++++++++
 tb/tb_pdm_audio_frontend.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: speaker output mode encodings and a width helper shared by the audio front end
package audio_pkg;
  typedef enum logic [1:0] {
    MODE_MUTE     = 2'd0,
    MODE_PASSTHRU = 2'd1,
    MODE_TIMER    = 2'd2,
    MODE_REMOD    = 2'd3
  } mode_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous FIFO with a registered head (no fall-through); a full FIFO accepts push+pop.
module pcm_fifo
  import audio_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_pop, w_push;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_dout = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
endmodule

// File: rtl/pdm_audio_frontend.sv
// pdm_audio_frontend: PDM mic clock, input synchronizer, boxcar decimation into a PCM FIFO,
// and the registered speaker PWM mux (mute / passthrough / timer / re-modulated PCM).
module pdm_audio_frontend
  import audio_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int HALF_DIV = 17,
  parameter int DECIM = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int PCM_W = clog2(DECIM + 1)
) (
  input  logic             clk_100MHz,
  input  logic             sysreset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             timer_pwm,
  input  logic             mic_data,
  output logic             mic_clk,
  output logic             mic_lrsel,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             aud_pwm,
  output logic             aud_sd
);
  localparam int DW = clog2(HALF_DIV);
  localparam int BW = clog2(DECIM);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bits, r_tick;
  logic [PCM_W-1:0] r_acc, r_last, r_held, w_sum;
  logic r_mic_clk, r_ovf, r_pwm, r_sd;
  logic w_bit, w_tc, w_strobe, w_push, w_pop, w_drop, w_full, w_empty, w_wrap, w_gen;
  assign w_bit = r_sync[SYNC_STAGES-1];
  assign w_tc = r_div == DW'(HALF_DIV - 1);
  assign w_strobe = en && w_tc && r_mic_clk;
  assign w_push = w_strobe && r_bits == BW'(DECIM - 1);
  assign w_sum = r_acc + PCM_W'(w_bit);
  assign w_pop = !w_empty && pcm_ready;
  assign w_drop = w_push && w_full && !w_pop;
  assign w_wrap = w_strobe && r_tick == BW'(DECIM - 1);
  assign w_gen = PCM_W'(r_tick) < r_held;
  assign mic_clk = r_mic_clk;
  assign mic_lrsel = 1'b1;
  assign pcm_valid = !w_empty;
  assign ovf = r_ovf;
  assign aud_pwm = r_pwm;
  assign aud_sd = r_sd;
  always_ff @(posedge clk_100MHz)
    if (!sysreset_n) begin
      r_sync <= '0;
      r_div <= '0;
      r_mic_clk <= 1'b0;
      r_bits <= '0;
      r_acc <= '0;
      r_tick <= '0;
      r_last <= '0;
      r_held <= '0;
      r_ovf <= 1'b0;
      r_pwm <= 1'b0;
      r_sd <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], mic_data};
      r_pwm <= mode == MODE_PASSTHRU ? w_bit : mode == MODE_TIMER ? timer_pwm : mode == MODE_REMOD ? w_gen : 1'b0;
      r_sd <= mode != MODE_MUTE;
      r_ovf <= w_drop || (r_ovf && !ovf_clr);
      if (w_push) r_last <= w_sum;
      if (w_strobe) r_tick <= w_wrap ? '0 : r_tick + 1'b1;
      // a sample pushed on the wrapping strobe is the most recent one, so bypass r_last
      if (w_wrap) r_held <= w_push ? w_sum : r_last;
      if (!en) begin
        r_div <= '0;
        r_mic_clk <= 1'b0;
        r_acc <= '0;
        r_bits <= '0;
      end else begin
        r_div <= w_tc ? '0 : r_div + 1'b1;
        if (w_tc) r_mic_clk <= !r_mic_clk;
        if (w_strobe) begin
          r_acc <= w_push ? '0 : w_sum;
          r_bits <= w_push ? '0 : r_bits + 1'b1;
        end
      end
    end
  pcm_fifo #(.W(PCM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_100MHz),
    .rst_n(sysreset_n),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_din(w_sum),
    .o_dout(pcm_data),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_pdm_audio_frontend.sv
// tb_pdm_audio_frontend: directed tables and sequences plus a randomized run against a
// cycle-level behavioural model of clocking, decimation, FIFO and output modes.
module tb_pdm_audio_frontend;
  import audio_pkg::*;
  localparam int SS = 3, HD = 2, DC = 8, FD = 4, PW = 4;
  logic clk = 0, rst_n = 0, en = 0, timer_pwm = 0, mic_data = 0, pcm_ready = 0, ovf_clr = 0;
  logic [1:0] mode = 2'd0;
  logic mic_clk, mic_lrsel, pcm_valid, ovf, aud_pwm, aud_sd;
  logic [PW-1:0] pcm_data;
  int n_chk = 0, n_fail = 0, gcnt = 0, src = 0;
  logic cbit = 0;
  logic [7:0] pat = 8'h07;
  logic sq[$] = '{1'b0, 1'b0, 1'b0};
  int mk = 0, macc = 0, mnb = 0;
  int mq[$];
  logic movf = 0, mpwm = 0, msd = 0, mclk = 0, mremod = 0;
  typedef struct {logic [1:0] md; logic tp; logic mic; logic exp_pwm; logic exp_sd;} vec_t;
  vec_t tbl[7];

  pdm_audio_frontend #(.SYNC_STAGES(SS), .HALF_DIV(HD), .DECIM(DC), .FIFO_DEPTH(FD)) dut (
    .clk_100MHz(clk), .sysreset_n(rst_n), .en(en), .mode(mode), .timer_pwm(timer_pwm),
    .mic_data(mic_data), .mic_clk(mic_clk), .mic_lrsel(mic_lrsel), .pcm_data(pcm_data),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .ovf(ovf), .ovf_clr(ovf_clr),
    .aud_pwm(aud_pwm), .aud_sd(aud_sd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // mic bit delayed by the synchronizer depth, strobes every 2*HD enabled cycles, windows of DC strobes
  task automatic model_step();
    logic s, strobe, pop, drop;
    if (!rst_n) begin
      sq = '{1'b0, 1'b0, 1'b0};
      mk = 0; macc = 0; mnb = 0; mq.delete();
      mclk = 0; movf = 0; mpwm = 0; msd = 0; mremod = 0;
      return;
    end
    s = sq.pop_front();
    sq.push_back(mic_data);
    strobe = 0;
    drop = 0;
    if (en) begin
      strobe = ((mk + 1) % (2 * HD)) == 0;
      mk++;
      mclk = ((mk / HD) % 2) == 1;
    end else begin
      mk = 0; mclk = 0; macc = 0; mnb = 0;
    end
    pop = mq.size() > 0 && pcm_ready;
    if (pop) void'(mq.pop_front());
    if (strobe) begin
      macc += int'(s);
      mnb++;
      if (mnb == DC) begin
        if (mq.size() < FD) mq.push_back(macc);
        else drop = 1;
        macc = 0; mnb = 0;
      end
    end
    movf = drop ? 1'b1 : ovf_clr ? 1'b0 : movf;
    msd = mode != MODE_MUTE;
    mpwm = mode == MODE_PASSTHRU ? s : mode == MODE_TIMER ? timer_pwm : 1'b0;
    mremod = mode == MODE_REMOD;
  endtask

  task automatic compare();
    chk("mic_clk", 32'(mic_clk), 32'(mclk));
    chk("pcm_valid", 32'(pcm_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("pcm_data", 32'(pcm_data), mq[0]);
    chk("ovf", 32'(ovf), 32'(movf));
    chk("aud_sd", 32'(aud_sd), 32'(msd));
    if (!mremod) chk("aud_pwm", 32'(aud_pwm), 32'(mpwm));
    chk("mic_lrsel", 32'(mic_lrsel), 1);
  endtask

  task automatic cyc();
    case (src)
      1: mic_data = 1'((gcnt / 4) % 2);
      2: mic_data = 1'($urandom % 2);
      3: mic_data = pat[(gcnt / 4) % 8];
      default: mic_data = cbit;
    endcase
    model_step();
    @(posedge clk);
    gcnt++;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; pcm_ready = 0; ovf_clr = 0; mode = MODE_MUTE; timer_pwm = 0;
    repeat (3) cyc();
    rst_n = 1;
  endtask

  initial begin
    int hi, got;
    tbl[0] = '{MODE_MUTE, 1, 1, 0, 0};
    tbl[1] = '{MODE_TIMER, 1, 0, 1, 1};
    tbl[2] = '{MODE_TIMER, 0, 1, 0, 1};
    tbl[3] = '{MODE_PASSTHRU, 0, 1, 1, 1};
    tbl[4] = '{MODE_PASSTHRU, 1, 0, 0, 1};
    tbl[5] = '{MODE_MUTE, 0, 0, 0, 0};
    tbl[6] = '{MODE_TIMER, 1, 1, 1, 1};
    @(negedge clk);
    do_reset();
    chk("rst_mic_clk", 32'(mic_clk), 0);
    chk("rst_pcm_valid", 32'(pcm_valid), 0);
    chk("rst_pcm_data", 32'(pcm_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_aud_pwm", 32'(aud_pwm), 0);
    chk("rst_aud_sd", 32'(aud_sd), 0);
    chk("rst_mic_lrsel", 32'(mic_lrsel), 1);
    // constant ones: clock phase and first full window
    src = 0; cbit = 1; en = 1;
    for (int n = 1; n <= 32; n++) begin
      cyc();
      if (n == 1 || n == 2 || n == 4 || n == 6) chk("mic_clk_phase", 32'(mic_clk), (n == 2 || n == 6) ? 1 : 0);
      if (n == 31) chk("valid_early", 32'(pcm_valid), 0);
    end
    chk("valid_at_32", 32'(pcm_valid), 1);
    chk("ones_sample", 32'(pcm_data), 8);
    pcm_ready = 1; cyc(); pcm_ready = 0;
    chk("popped_empty", 32'(pcm_valid), 0);
    // alternating bits
    do_reset();
    src = 1; en = 1; pcm_ready = 1; got = 0;
    for (int i = 0; i < 200 && got < 3; i++) begin
      cyc();
      if (pcm_valid) begin
        chk("alt_sample", 32'(pcm_data), 4);
        got++;
      end
    end
    chk("alt_count", got, 3);
    // overflow and clear
    do_reset();
    src = 0; cbit = 1; en = 1;
    repeat (128) cyc();
    chk("four_held_valid", 32'(pcm_valid), 1);
    chk("four_held_no_ovf", 32'(ovf), 0);
    repeat (32) cyc();
    chk("fifth_dropped_ovf", 32'(ovf), 1);
    for (int i = 0; i < 4; i++) begin
      chk("held_valid", 32'(pcm_valid), 1);
      chk("held_data", 32'(pcm_data), 8);
      pcm_ready = 1; cyc(); pcm_ready = 0;
    end
    chk("drained", 32'(pcm_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1; cyc(); ovf_clr = 0;
    chk("ovf_cleared", 32'(ovf), 0);
    for (int i = 0; i < 200 && mq.size() < FD; i++) cyc();
    for (int i = 0; i < 40; i++) begin
      pcm_ready = (mnb == DC - 1 && (mk + 1) % (2 * HD) == 0);
      cyc();
      if (pcm_ready) break;
    end
    pcm_ready = 0;
    chk("full_pushpop_no_ovf", 32'(ovf), 0);
    chk("full_pushpop_valid", 32'(pcm_valid), 1);
    // REMOD generator
    do_reset();
    src = 3; pat = 8'h07; en = 1; pcm_ready = 1; mode = MODE_REMOD;
    repeat (96) cyc();
    hi = 0;
    repeat (32) begin cyc(); hi += int'(aud_pwm); end
    chk("remod3_high_cycles", hi, 12);
    chk("remod_sd", 32'(aud_sd), 1);
    src = 0; cbit = 1;
    repeat (96) cyc();
    hi = 0;
    repeat (32) begin cyc(); hi += int'(aud_pwm); end
    chk("remod8_high_cycles", hi, 32);
    // mode sweep table
    do_reset();
    src = 0;
    foreach (tbl[i]) begin
      mode = tbl[i].md; timer_pwm = tbl[i].tp; cbit = tbl[i].mic;
      repeat (5) cyc();
      chk("sweep_pwm", 32'(aud_pwm), 32'(tbl[i].exp_pwm));
      chk("sweep_sd", 32'(aud_sd), 32'(tbl[i].exp_sd));
    end
    mode = MODE_TIMER;
    repeat (8) begin
      timer_pwm = 1'($urandom % 2);
      cyc();
      chk("timer_delay1", 32'(aud_pwm), 32'(timer_pwm));
    end
    mode = MODE_PASSTHRU; cbit = 0;
    repeat (5) cyc();
    cbit = 1;
    for (int n = 1; n <= 4; n++) begin
      cyc();
      if (n >= 3) chk("passthru_latency", 32'(aud_pwm), n == 4 ? 1 : 0);
    end
    // enable dropped mid-window after five ones
    do_reset();
    src = 0; cbit = 1; en = 1;
    repeat (22) cyc();
    chk("mic_clk_before_drop", 32'(mic_clk), 1);
    en = 0;
    repeat (12) begin
      cyc();
      chk("disabled_mic_clk", 32'(mic_clk), 0);
    end
    chk("disabled_no_push", 32'(pcm_valid), 0);
    en = 1;
    for (int n = 1; n <= 32; n++) begin
      cyc();
      if (n == 31) chk("reenable_valid_early", 32'(pcm_valid), 0);
    end
    chk("reenable_valid", 32'(pcm_valid), 1);
    chk("reenable_sample", 32'(pcm_data), 8);
    // reset mid-window discards FIFO and partial sum
    repeat (10) cyc();
    do_reset();
    chk("reset_flushes", 32'(pcm_valid), 0);
    en = 1;
    for (int n = 1; n <= 32; n++) begin
      cyc();
      if (n == 31) chk("post_reset_valid_early", 32'(pcm_valid), 0);
    end
    chk("post_reset_sample", 32'(pcm_data), 8);
    // randomized run against the model
    do_reset();
    src = 2; en = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 1500) != 0;
      if (en) en = ($urandom % 250) != 0;
      else en = ($urandom % 8) == 0;
      mode = 2'($urandom % 4);
      timer_pwm = 1'($urandom % 2);
      pcm_ready = ((i / 400) % 2 == 1) ? ($urandom % 8) == 0 : ($urandom % 4) != 0;
      ovf_clr = ($urandom % 64) == 0;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
